// File: rtl/timetag_pkg.sv
// Shared sample-format constants and the demultiplexer state type, common to
// the byte serializer and the byte-to-sample deserializer.
package timetag_pkg;

  localparam int unsigned SAMPLE_BYTES = 6;
  localparam int unsigned SAMPLE_W     = 8 * SAMPLE_BYTES;

  typedef enum logic {
    ACC  = 1'b0,
    FULL = 1'b1
  } demux_state_t;

endpackage

// File: rtl/idle_timer.sv
// Inter-byte idle timer: counts while run is high and raises a registered
// one-cycle expire pulse once TIMEOUT idle cycles have elapsed.
module idle_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          expire_q, expire_d;

  // The expire cycle itself restarts the count so one timeout gives one pulse.
  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (clear || expire_q) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d    = cnt_q + TW'(1);
      expire_d = (cnt_q == LAST);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire = expire_q;

endmodule

// File: rtl/sample_demultiplexer.sv
// Byte-to-sample deserializer: MSB-first byte accumulator, one-word output
// holding register and an idle timeout that discards partial samples.
module sample_demultiplexer
  import timetag_pkg::*;
#(
  parameter int unsigned BYTES   = SAMPLE_BYTES,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         data,
  input  logic               data_rdy,
  output logic               data_ack,
  output logic [8*BYTES-1:0] sample,
  output logic               sample_rdy,
  input  logic               sample_ack,
  output logic               frame_err
);

  localparam int unsigned SW = 8 * BYTES;
  localparam int unsigned CW = $clog2(BYTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(BYTES - 1);

  demux_state_t  state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] acc_q, acc_d;
  logic [SW-1:0] sample_q, sample_d;
  logic          out_valid_q, out_valid_d;

  logic          byte_xfer;
  logic          out_free;
  logic          load;
  logic [SW-1:0] load_word;
  logic [SW-1:0] acc_shift;
  logic          timer_run;
  logic          timer_clear;
  logic          expire;

  assign data_ack    = reset_n && (state_q == ACC);
  assign byte_xfer   = data_rdy && data_ack;
  assign out_free    = !out_valid_q || sample_ack;
  assign acc_shift   = {acc_q[SW-9:0], data};
  assign timer_run   = (state_q == ACC) && (count_q != '0) && !byte_xfer;
  assign timer_clear = byte_xfer || (count_q == '0);

  if (TIMEOUT > 0) begin : g_timer
    idle_timer #(
      .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (timer_run),
      .clear   (timer_clear),
      .expire  (expire)
    );
  end else begin : g_no_timer
    assign expire = 1'b0;
  end

  // Framing and stall control; a byte landing on the expire cycle starts a new sample.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    load      = 1'b0;
    load_word = acc_q;
    unique case (state_q)
      ACC: begin
        if (expire) begin
          count_d = byte_xfer ? CW'(1) : '0;
          if (byte_xfer) acc_d = acc_shift;
        end else if (byte_xfer) begin
          acc_d = acc_shift;
          if (count_q == LAST_IDX) begin
            if (out_free) begin
              load      = 1'b1;
              load_word = acc_shift;
              count_d   = '0;
            end else begin
              state_d = FULL;
              count_d = CW'(BYTES);
            end
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      FULL: begin
        if (out_free) begin
          load      = 1'b1;
          load_word = acc_q;
          count_d   = '0;
          state_d   = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // Output holding register: a load wins over a same-cycle acknowledge.
  always_comb begin
    out_valid_d = load || (out_valid_q && !sample_ack);
    sample_d    = load ? load_word : sample_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ACC;
      count_q     <= '0;
      acc_q       <= '0;
      sample_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      sample_q    <= sample_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sample     = sample_q;
  assign sample_rdy = out_valid_q;
  assign frame_err  = expire;

endmodule

// File: tb/tb_sample_demultiplexer.sv
// Bench for sample_demultiplexer: directed scenarios with literal expectations
// plus randomized traffic, all cross-checked every cycle against a byte-queue model.
module tb_sample_demultiplexer;

  localparam int unsigned BYTES   = 6;
  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned SW      = 8 * BYTES;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    data;
  logic          data_rdy;
  logic          data_ack;
  logic [SW-1:0] sample;
  logic          sample_rdy;
  logic          sample_ack;
  logic          frame_err;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;

  always #5 clk = ~clk;

  sample_demultiplexer #(
    .BYTES   (BYTES),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data       (data),
    .data_rdy   (data_rdy),
    .data_ack   (data_ack),
    .sample     (sample),
    .sample_rdy (sample_rdy),
    .sample_ack (sample_ack),
    .frame_err  (frame_err)
  );

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes of the current partial sample, a stalled full word,
  // the output word, and a count of consecutive idle cycles since the last byte.
  logic [7:0]    m_part[$];
  bit            m_stalled;
  logic [SW-1:0] m_stall_w;
  bit            m_ov;
  logic [SW-1:0] m_ow;
  bit            m_fe;
  int            m_idle;

  bit            t_xfer, t_free, t_load, t_nfe;
  logic [SW-1:0] t_word;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_part.delete();
      m_stalled = 0;
      m_stall_w = '0;
      m_ov      = 0;
      m_ow      = '0;
      m_fe      = 0;
      m_idle    = 0;
    end else begin
      t_xfer = data_rdy && !m_stalled;
      t_free = !m_ov || sample_ack;
      t_load = 0;
      t_nfe  = 0;
      t_word = '0;
      if (!m_stalled) begin
        if (t_xfer || m_part.size() == 0 || m_fe) m_idle = 0;
        else begin
          m_idle++;
          t_nfe = (m_idle == int'(TIMEOUT));
        end
      end
      if (m_stalled) begin
        if (t_free) begin
          t_load    = 1;
          t_word    = m_stall_w;
          m_stalled = 0;
        end
      end else if (m_fe) begin
        m_part.delete();
        if (t_xfer) m_part.push_back(data);
      end else if (t_xfer) begin
        m_part.push_back(data);
        if (m_part.size() == BYTES) begin
          foreach (m_part[i]) t_word = {t_word[SW-9:0], m_part[i]};
          m_part.delete();
          if (t_free) t_load = 1;
          else begin
            m_stalled = 1;
            m_stall_w = t_word;
          end
        end
      end
      if (t_load) begin
        m_ov = 1;
        m_ow = t_word;
      end else if (sample_ack) begin
        m_ov = 0;
      end
      m_fe = t_nfe;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("data_ack",   SW'(data_ack),   SW'(reset_n && !m_stalled));
    chk("sample_rdy", SW'(sample_rdy), SW'(m_ov));
    chk("sample",     sample,          m_ow);
    chk("frame_err",  SW'(frame_err),  SW'(m_fe));
    if (frame_err) fe_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    data_rdy   = 1'b0;
    data       = '0;
    sample_ack = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic send_run(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      data     = first + 8'(i);
      data_rdy = 1'b1;
      tick();
    end
    data_rdy = 1'b0;
  endtask

  int fe_base;

  initial begin
    reset_n    = 1'b0;
    data_rdy   = 1'b0;
    data       = '0;
    sample_ack = 1'b0;
    #2;
    chk("rst_data_ack", SW'(data_ack), '0);
    chk("rst_sample", sample, '0);

    // Six consecutive bytes with the consumer always ready.
    do_reset();
    chk("post_rst_data_ack", SW'(data_ack), SW'(1));
    chk("post_rst_sample_rdy", SW'(sample_rdy), '0);
    fe_base    = fe_cnt;
    sample_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data     = 8'hA1 + 8'(i * 8'h11);
      data_rdy = 1'b1;
      tick();
    end
    data_rdy = 1'b0;
    chk("t1_sample", sample, 48'hA1B2C3D4E5F6);
    chk("t1_rdy", SW'(sample_rdy), SW'(1));
    tick();
    chk("t1_rdy_drop", SW'(sample_rdy), '0);
    chk("t1_no_ferr", SW'(fe_cnt - fe_base), '0);

    // Two back-to-back samples with the consumer stalled.
    do_reset();
    send_run(8'h10, 12);
    chk("t2_first_held", sample, 48'h101112131415);
    chk("t2_full_ack", SW'(data_ack), '0);
    chk("t2_rdy", SW'(sample_rdy), SW'(1));
    sample_ack = 1'b1;
    tick();
    sample_ack = 1'b0;
    chk("t2_second", sample, 48'h161718191A1B);
    chk("t2_ack_back", SW'(data_ack), SW'(1));

    // Partial sample abandoned for 255 idle cycles.
    do_reset();
    fe_base    = fe_cnt;
    sample_ack = 1'b1;
    send_run(8'h77, 3);
    repeat (254) tick();
    chk("t3_ferr_early", SW'(frame_err), '0);
    tick();
    chk("t3_ferr", SW'(frame_err), SW'(1));
    send_run(8'h01, 6);
    chk("t3_sample", sample, 48'h010203040506);
    chk("t3_ferr_once", SW'(fe_cnt - fe_base), SW'(1));

    // A 254-cycle gap stays inside the timeout.
    do_reset();
    fe_base = fe_cnt;
    send_run(8'h51, 3);
    repeat (254) tick();
    send_run(8'h54, 3);
    chk("t4_sample", sample, 48'h515253545556);
    chk("t4_no_ferr", SW'(fe_cnt - fe_base), '0);

    // Asynchronous reset mid-sample.
    do_reset();
    send_run(8'h60, 4);
    #2 reset_n = 1'b0;
    #1;
    chk("t5a_ack", SW'(data_ack), '0);
    chk("t5a_rdy", SW'(sample_rdy), '0);
    chk("t5a_ferr", SW'(frame_err), '0);
    tick();
    reset_n = 1'b1;
    tick();

    // Asynchronous reset while stalled, then a clean sample.
    send_run(8'h80, 12);
    chk("t5b_full", SW'(data_ack), '0);
    #2 reset_n = 1'b0;
    #1;
    chk("t5b_ack", SW'(data_ack), '0);
    chk("t5b_rdy", SW'(sample_rdy), '0);
    chk("t5b_sample", sample, '0);
    tick();
    reset_n    = 1'b1;
    tick();
    sample_ack = 1'b1;
    send_run(8'h40, 6);
    chk("t5b_clean", sample, 48'h404142434445);

    // Acknowledge coincident with the last byte of the next sample.
    do_reset();
    send_run(8'h20, 6);
    send_run(8'h30, 5);
    data       = 8'h35;
    data_rdy   = 1'b1;
    sample_ack = 1'b1;
    tick();
    data_rdy = 1'b0;
    chk("t6_rdy", SW'(sample_rdy), SW'(1));
    chk("t6_sample", sample, 48'h303132333435);
    chk("t6_ack", SW'(data_ack), SW'(1));
    tick();
    sample_ack = 1'b0;
    chk("t6_drained", SW'(sample_rdy), '0);

    // Randomized traffic with occasional long idle gaps.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        data_rdy   = 1'b0;
        sample_ack = $urandom_range(0, 1) == 1;
        repeat ($urandom_range(250, 260)) tick();
      end
      data       = 8'($urandom);
      data_rdy   = $urandom_range(0, 3) != 0;
      sample_ack = $urandom_range(0, 1) == 1;
      tick();
    end
    data_rdy   = 1'b0;
    sample_ack = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
